// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine for pre-padded 512-bit blocks with multi-block chaining,
// midstate preload, configurable rounds per clock and optional in-engine SHA256d.
module sha256_stream_core #(
  parameter int UNROLL    = 1,
  parameter bit DOUBLE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         use_mid,
  input  logic [255:0] midstate_in,
  input  logic         dbl,
  input  logic         abort,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2 or 4");
  end

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t         state_q, state_d;
  logic [5:0]     rnd_q, rnd_d;
  logic [31:0]    hash_q [8];
  logic [31:0]    hash_d [8];
  logic [31:0]    wv_q [8];
  logic [31:0]    wv_d [8];
  logic [31:0]    w_q [16];
  logic [31:0]    w_d [16];
  logic           last_q, last_d;
  logic           dbl_q, dbl_d;
  logic           pass2_q, pass2_d;
  logic           dv_q, dv_d;
  logic [255:0]   digest_q, digest_d;

  logic [31:0]    rv [8];
  logic [31:0]    ext [16+UNROLL];
  logic [31:0]    sum_v [8];
  logic [31:0]    t1, t2;
  logic [255:0]   start_v;

  // UNROLL chained rounds; ext[16..] are the schedule words that slide into the window.
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int k = 0; k < 8; k++) rv[k] = wv_q[k];
    for (int k = 0; k < 16; k++) ext[k] = w_q[k];
    for (int k = 16; k < 16 + UNROLL; k++) ext[k] = '0;
    for (int j = 0; j < UNROLL; j++) begin
      t1 = rv[7] + big_s1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
         + K_TAB[rnd_q + 6'(j)] + ext[j];
      t2 = big_s0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      rv[7] = rv[6];
      rv[6] = rv[5];
      rv[5] = rv[4];
      rv[4] = rv[3] + t1;
      rv[3] = rv[2];
      rv[2] = rv[1];
      rv[1] = rv[0];
      rv[0] = t1 + t2;
      ext[16+j] = sml_s1(ext[14+j]) + ext[9+j] + sml_s0(ext[1+j]) + ext[j];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) sum_v[k] = hash_q[k] + wv_q[k];
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    last_d   = last_q;
    dbl_d    = dbl_q;
    pass2_d  = pass2_q;
    dv_d     = 1'b0;
    digest_d = digest_q;
    for (int k = 0; k < 8; k++) begin
      hash_d[k] = hash_q[k];
      wv_d[k]   = wv_q[k];
    end
    for (int k = 0; k < 16; k++) w_d[k] = w_q[k];
    start_v = blk_first ? (use_mid ? midstate_in : IV) : {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                                                         hash_q[4], hash_q[5], hash_q[6], hash_q[7]};

    if (abort) begin
      state_d = S_IDLE;
      pass2_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (blk_valid) begin
            for (int k = 0; k < 8; k++) begin
              wv_d[k] = start_v[255-32*k -: 32];
              if (blk_first) hash_d[k] = start_v[255-32*k -: 32];
            end
            for (int k = 0; k < 16; k++) w_d[k] = blk_data[511-32*k -: 32];
            last_d  = blk_last;
            dbl_d   = blk_first ? dbl : dbl_q;
            pass2_d = 1'b0;
            rnd_d   = '0;
            state_d = S_ROUND;
          end
        end
        S_ROUND: begin
          for (int k = 0; k < 8; k++) wv_d[k] = rv[k];
          for (int k = 0; k < 16; k++) w_d[k] = ext[k+UNROLL];
          rnd_d = rnd_q + 6'(UNROLL);
          if (rnd_q == 6'(64 - UNROLL)) state_d = S_FINAL;
        end
        S_FINAL: begin
          if (last_q && dbl_q && DOUBLE_EN && !pass2_q) begin
            // Second pass hashes the 32-byte digest, padded to one block.
            for (int k = 0; k < 8; k++) begin
              hash_d[k] = IV[255-32*k -: 32];
              wv_d[k]   = IV[255-32*k -: 32];
              w_d[k]    = sum_v[k];
            end
            w_d[8] = 32'h8000_0000;
            for (int k = 9; k < 15; k++) w_d[k] = '0;
            w_d[15] = 32'd256;
            pass2_d = 1'b1;
            rnd_d   = '0;
            state_d = S_ROUND;
          end else begin
            for (int k = 0; k < 8; k++) hash_d[k] = sum_v[k];
            state_d = last_q ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          digest_d = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                      hash_q[4], hash_q[5], hash_q[6], hash_q[7]};
          dv_d    = 1'b1;
          pass2_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      rnd_q    <= '0;
      last_q   <= 1'b0;
      dbl_q    <= 1'b0;
      pass2_q  <= 1'b0;
      dv_q     <= 1'b0;
      digest_q <= '0;
      for (int k = 0; k < 8; k++) begin
        hash_q[k] <= IV[255-32*k -: 32];
        wv_q[k]   <= '0;
      end
      for (int k = 0; k < 16; k++) w_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      last_q   <= last_d;
      dbl_q    <= dbl_d;
      pass2_q  <= pass2_d;
      dv_q     <= dv_d;
      digest_q <= digest_d;
      for (int k = 0; k < 8; k++) begin
        hash_q[k] <= hash_d[k];
        wv_q[k]   <= wv_d[k];
      end
      for (int k = 0; k < 16; k++) w_q[k] <= w_d[k];
    end
  end

  assign blk_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign digest_valid = dv_q;
  assign digest       = digest_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: three engines (UNROLL=1, UNROLL=4, UNROLL=4 without SHA256d) checked
// against known digests, latencies and abort/reset behaviour.
module tb_sha256_stream_core;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] H1  = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_DBL  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [2:0]   vld;
  logic [511:0] blk_data;
  logic         blk_first, blk_last, use_mid, dbl, abort;
  logic [255:0] midstate_in;
  logic         rdy0, rdy1, rdy2;
  logic         dv0, dv1, dv2;
  logic         bsy0, bsy1, bsy2;
  logic [255:0] dig0, dig1, dig2;

  int checks = 0;
  int failures = 0;
  int cyc;
  int seen;

  always #5 clk = ~clk;

  sha256_stream_core #(.UNROLL(1), .DOUBLE_EN(1'b1)) dut0 (
    .clk(clk), .n_rst(n_rst), .blk_valid(vld[0]), .blk_ready(rdy0), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .use_mid(use_mid), .midstate_in(midstate_in),
    .dbl(dbl), .abort(abort), .digest_valid(dv0), .digest(dig0), .busy(bsy0));

  sha256_stream_core #(.UNROLL(4), .DOUBLE_EN(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .blk_valid(vld[1]), .blk_ready(rdy1), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .use_mid(use_mid), .midstate_in(midstate_in),
    .dbl(dbl), .abort(abort), .digest_valid(dv1), .digest(dig1), .busy(bsy1));

  sha256_stream_core #(.UNROLL(4), .DOUBLE_EN(1'b0)) dut2 (
    .clk(clk), .n_rst(n_rst), .blk_valid(vld[2]), .blk_ready(rdy2), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .use_mid(use_mid), .midstate_in(midstate_in),
    .dbl(dbl), .abort(abort), .digest_valid(dv2), .digest(dig2), .busy(bsy2));

  function automatic logic get_dv(input int i);
    return (i == 0) ? dv0 : (i == 1) ? dv1 : dv2;
  endfunction

  function automatic logic [255:0] get_dig(input int i);
    return (i == 0) ? dig0 : (i == 1) ? dig1 : dig2;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int i, input logic [511:0] d, input logic f, input logic l,
                      input logic um, input logic [255:0] mid, input logic db);
    @(negedge clk);
    blk_data = d; blk_first = f; blk_last = l; use_mid = um; midstate_in = mid; dbl = db;
    vld[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_dv(input int i, output int n);
    n = 0;
    while (!get_dv(i) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic watch_no_dv(input int i, input int n, output int s);
    s = 0;
    repeat (n) begin
      @(negedge clk);
      if (get_dv(i)) s++;
    end
  endtask

  initial begin
    n_rst = 1'b0; vld = '0; blk_data = '0; blk_first = 1'b0; blk_last = 1'b0;
    use_mid = 1'b0; dbl = 1'b0; abort = 1'b0; midstate_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", bsy0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_digest", dig0, 0);
    n_rst = 1'b1;

    // single block "abc"
    send(0, ABC, 1, 1, 0, '0, 0);
    wait_dv(0, cyc);
    chk("abc_latency", cyc, 66);
    chk("abc_digest", dig0, D_ABC);
    @(negedge clk);
    chk("abc_dv_width", dv0, 0);

    // two-block message
    send(0, B1, 1, 0, 0, '0, 0);
    cyc = 1;
    while (!rdy0 && cyc < 300) begin
      @(negedge clk);
      if (!rdy0) cyc++;
    end
    chk("two_ready_low", cyc, 65);
    send(0, B2, 0, 1, 0, '0, 0);
    wait_dv(0, cyc);
    chk("two_latency", cyc, 66);
    chk("two_digest", dig0, D_TWO);

    // midstate preload
    send(0, B2, 1, 1, 1, H1, 0);
    wait_dv(0, cyc);
    chk("mid_digest", dig0, D_TWO);

    // abort during ROUND
    send(0, ABC, 1, 1, 0, '0, 0);
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", rdy0, 1);
    chk("abort_busy", bsy0, 0);
    watch_no_dv(0, 80, seen);
    chk("abort_no_dv", seen, 0);
    chk("abort_digest_kept", dig0, D_TWO);
    send(0, ABC, 1, 1, 0, '0, 0);
    wait_dv(0, cyc);
    chk("post_abort_digest", dig0, D_ABC);

    // abort concurrent with a transfer discards the block
    @(negedge clk);
    blk_data = B1; blk_first = 1'b1; blk_last = 1'b1; vld[0] = 1'b1; abort = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0; abort = 1'b0;
    chk("abort_xfer_busy", bsy0, 0);
    watch_no_dv(0, 80, seen);
    chk("abort_xfer_no_dv", seen, 0);

    // reset mid-ROUND, then a non-first block continues from the IV
    send(0, B1, 1, 1, 0, '0, 0);
    repeat (10) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_ready", rdy0, 1);
    chk("midrst_busy", bsy0, 0);
    chk("midrst_dv", dv0, 0);
    chk("midrst_digest", dig0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    send(0, ABC, 0, 1, 0, '0, 0);
    wait_dv(0, cyc);
    chk("nonfirst_after_rst", dig0, D_ABC);

    // valid held while busy is ignored, then accepted once ready
    send(0, B2, 1, 1, 1, H1, 0);
    vld[0] = 1'b1;
    wait_dv(0, cyc);
    chk("held_first_latency", cyc, 66);
    chk("held_first_digest", dig0, D_TWO);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    chk("held_accepted", bsy0, 1);
    wait_dv(0, cyc);
    chk("held_second_latency", cyc, 66);
    chk("held_second_digest", dig0, D_TWO);

    // UNROLL=4 engines
    send(1, ABC, 1, 1, 0, '0, 1);
    wait_dv(1, cyc);
    chk("dbl_latency", cyc, 35);
    chk("dbl_digest", dig1, D_DBL);
    send(1, ABC, 1, 1, 0, '0, 0);
    wait_dv(1, cyc);
    chk("u4_latency", cyc, 18);
    chk("u4_digest", dig1, D_ABC);
    send(2, ABC, 1, 1, 0, '0, 1);
    wait_dv(2, cyc);
    chk("nodbl_latency", cyc, 18);
    chk("nodbl_digest", dig2, D_ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Parametrised SHA-256 compression engine accepting pre-padded 512-bit blocks over a valid/ready handshake; chains any number of blocks per message.
- Adds configurable rounds-per-cycle unrolling, midstate preload for header-nonce search, and optional in-engine double SHA-256 (SHA256d).
- Sits between the block formatter/nonce generator and the target comparator in the miner datapath.
- Message preprocessing and padding are the upstream formatter's responsibility, except for the second pass of SHA256d.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- DOUBLE_EN, 1, 1 = SHA256d mode available; 0 = dbl input ignored and second-pass logic removed.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- blk_valid  in  1  blk_* fields valid.
- blk_ready  out  1  engine can accept a block.
- blk_data  in  512  padded block; [511:480] = W0, big-endian words.
- blk_first  in  1  block starts a new message; hash loaded from IV or midstate.
- blk_last  in  1  block ends the message.
- use_mid  in  1  with blk_first: initial hash = midstate_in instead of IV.
- midstate_in  in  256  [255:224] = H0.
- dbl  in  1  sampled with blk_first: SHA256d.
- abort  in  1  synchronous cancel.
- digest_valid  out  1  one-cycle pulse, digest updated.
- digest  out  256  [255:224] = H0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; blk_ready=1; digest_valid=0; digest=0; busy=0; hash regs = IV (6a09e667…5be0cd19); round counter=0.
- Handshake:
  - Transfer occurs on a clk edge where blk_valid && blk_ready.
  - blk_ready = (state==IDLE).
  - blk_valid while not ready has no effect; upstream holds its data.
- State machine, IDLE -> ROUND:
  - Taken on transfer.
  - Working vars a..h loaded from the selected start hash.
  - Start hash selection: if blk_first, IV or midstate_in (per use_mid), also written into hash regs; otherwise current hash regs.
  - Schedule window loaded from blk_data.
  - dbl and blk_last latched.
- ROUND:
  - Runs 64/UNROLL cycles; each cycle applies UNROLL rounds with K[i..i+UNROLL-1].
  - Schedule is a 16-word sliding window shifted by UNROLL words per cycle.
  - All arithmetic is mod 2^32.
  - After the last round cycle -> FINAL.
- FINAL (1 cycle): hash regs += a..h. Next state:
  - not last: IDLE.
  - last && !(dbl && DOUBLE_EN): DONE.
  - last && dbl && first pass: ROUND directly (second pass). Hash regs and a..h are loaded with IV. Schedule is loaded with {sum[255:0], 32'h80000000, 160'h0, 64'd256}, where sum is the just-computed hash. Second-pass flag set.
  - second pass: DONE.
- DONE (1 cycle):
  - digest <= hash regs; digest_valid=1 in this cycle; -> IDLE.
  - digest holds its value until the next DONE.
- Latency:
  - Single block, last, no dbl: transfer edge to digest_valid = 64/UNROLL + 2 cycles (66 at UNROLL=1, 18 at UNROLL=4).
  - SHA256d: 2*(64/UNROLL+1)+1 cycles.
  - Non-last block: blk_ready returns 64/UNROLL+1 cycles after transfer.
- abort:
  - In any state, next edge -> IDLE; no digest_valid; digest unchanged.
  - Hash regs keep their value; the next message must assert blk_first.
  - abort concurrent with a transfer: abort wins, block discarded.
- Boundaries:
  - blk_first with blk_last: single-block message.
  - Non-first block after an abort or reset continues from the current hash regs; this is defined behaviour, not an error.
  - use_mid/dbl on a non-first block are ignored.
  - n_rst asserted mid-ROUND: immediate return to reset values.

Test Plan:
- UNROLL=1: "abc" padded block (61626380, 0…, 00000018), first+last -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; digest_valid exactly 66 cycles after transfer, one cycle wide.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. Check that blk_ready drops for 65 cycles between the blocks.
- Midstate: capture the hash after block 1 of the previous test (abort after FINAL, read via a one-block run). Feed block 2 with blk_first+use_mid+midstate_in -> same 248d6a61… digest.
- SHA256d, "abc", dbl=1, UNROLL=4 -> 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358; latency 2*17+1=35 cycles. With DOUBLE_EN=0 the same stimulus yields ba7816bf….
- Assert abort on round cycle 30 -> no digest_valid, blk_ready=1 next cycle, digest unchanged. A subsequent "abc" first+last gives the correct digest.
- Assert n_rst mid-ROUND -> all outputs at reset values immediately. blk_valid held during busy has no effect, and the held block is accepted once ready.
